// File: rtl/feature_memory_slave_pkg.sv
// Shared definitions for the feature memory slave: bus FSM states and custom-instruction commands.
package feature_memory_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      WRITE,
      READ,
      ENDREAD,
      ERROR,
      WAITEND
   } busState_t;

   typedef enum logic [1:0] {
      CI_READ_WORD     = 2'd0,
      CI_READ_COUNTER  = 2'd1,
      CI_CLEAR_COUNTER = 2'd2,
      CI_GET_DEPTH     = 2'd3
   } ciCommand_t;

endpackage

// File: rtl/feature_memory_slave_ram.sv
// Word memory with a byte-writable bus port (A) and a read-only CI port (B), both with registered reads.
module dual_port_word_ram #(
   parameter int unsigned ADDRESS_WIDTH = 6
) (
   input  logic                     clock,
   input  logic [ADDRESS_WIDTH-1:0] addressA,
   input  logic                     writeEnableA,
   input  logic [3:0]               byteEnablesA,
   input  logic [31:0]              writeDataA,
   output logic [31:0]              readDataA,
   input  logic [ADDRESS_WIDTH-1:0] addressB,
   output logic [31:0]              readDataB
);

   logic [31:0] memory [0:(1 << ADDRESS_WIDTH) - 1];

   always_ff @(posedge clock) begin
      if (writeEnableA) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byteEnablesA[b]) memory[addressA][8*b +: 8] <= writeDataA[8*b +: 8];
         end
      end
      readDataA <= memory[addressA];
      readDataB <= memory[addressB];
   end

endmodule

// File: rtl/feature_memory_slave.sv
// Burst-bus responder holding a small word memory, with a custom-instruction side port for the CPU.
module feature_memory_slave
   import feature_memory_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS          = 32'h5000_0000,
   parameter int unsigned ADDRESS_WIDTH         = 6,
   parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd1
) (
   input  logic        systemClock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic [31:0] addressDataIn,
   input  logic        endTransactionIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic        readNotWriteIn,
   input  logic [7:0]  burstSizeIn,
   input  logic        dataValidIn,
   output logic        busyOut,
   output logic        busErrorOut,
   output logic [31:0] addressDataOut,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   input  logic        ciStart,
   input  logic        ciCke,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic [31:0] ciResult,
   output logic        ciDone
);

   localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

   busState_t                state, nextState;
   logic [ADDRESS_WIDTH-1:0] wordIndex;
   logic [8:0]               remaining;
   logic [3:0]               byteEnables;
   logic                     readNotWrite;
   logic                     misaligned;
   logic [31:0]              writeCounter;
   logic [31:0]              ramReadA, ramReadB;
   logic [31:0]              laneMask;
   logic                     addressHit, startHit, overrun;
   logic                     acceptWrite, overflowBeat, advanceIndex, consumeWord;
   logic                     ciActive, ciKnown, clearRequest;
   ciCommand_t               ciCommand;
   logic                     ciFromRam;
   logic [31:0]              ciValue;
   logic                     unusedCiOperand;

   assign addressHit   = addressDataIn[31:ADDRESS_WIDTH+2] == BASE_ADDRESS[31:ADDRESS_WIDTH+2];
   assign startHit     = (state == IDLE) && beginTransactionIn && addressHit;
   assign overrun      = (32'(wordIndex) + 32'(remaining)) > 32'(DEPTH - 1);
   // remaining[8] set means the counter wrapped past the last word of the burst
   assign acceptWrite  = (state == WRITE) && dataValidIn && !remaining[8];
   assign overflowBeat = (state == WRITE) && dataValidIn && remaining[8];
   // DECODE already presents the first read address, so the index moves on one cycle early
   assign advanceIndex = acceptWrite || (state == READ) || ((state == DECODE) && readNotWrite);
   assign consumeWord  = acceptWrite || (state == READ);

   assign ciActive        = ciStart && ciCke && (ciN == CUSTOM_INSTRUCTION_ID);
   assign ciKnown         = ciValueA[31:2] == '0;
   assign ciCommand       = ciCommand_t'(ciValueA[1:0]);
   assign clearRequest    = ciActive && ciKnown && (ciCommand == CI_CLEAR_COUNTER);
   assign unusedCiOperand = ^ciValueB[31:ADDRESS_WIDTH];

   dual_port_word_ram #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) ram (
      .clock       (systemClock),
      .addressA    (wordIndex),
      .writeEnableA(acceptWrite && !reset),
      .byteEnablesA(byteEnables),
      .writeDataA  (addressDataIn),
      .readDataA   (ramReadA),
      .addressB    (ciValueB[ADDRESS_WIDTH-1:0]),
      .readDataB   (ramReadB)
   );

   always_ff @(posedge systemClock) begin
      if (reset) begin
         state        <= IDLE;
         wordIndex    <= '0;
         remaining    <= '0;
         byteEnables  <= '0;
         readNotWrite <= 1'b0;
         misaligned   <= 1'b0;
      end else begin
         state <= nextState;
         if (startHit) begin
            wordIndex    <= addressDataIn[ADDRESS_WIDTH+1:2];
            byteEnables  <= byteEnablesIn;
            readNotWrite <= readNotWriteIn;
            remaining    <= {1'b0, burstSizeIn};
            misaligned   <= |addressDataIn[1:0];
         end else begin
            if (advanceIndex) wordIndex <= wordIndex + ADDRESS_WIDTH'(1);
            if (consumeWord) remaining <= remaining - 9'd1;
         end
      end
   end

   always_ff @(posedge systemClock) begin
      if (reset || clearRequest) writeCounter <= '0;
      else if (acceptWrite && (writeCounter != '1)) writeCounter <= writeCounter + 32'd1;
   end

   always_comb begin
      nextState         = state;
      busyOut           = 1'b0;
      busErrorOut       = overflowBeat;
      dataValidOut      = 1'b0;
      endTransactionOut = 1'b0;
      unique case (state)
         IDLE:    if (startHit) nextState = DECODE;
         DECODE: begin
            busyOut = 1'b1;
            if (misaligned || overrun) nextState = ERROR;
            else if (readNotWrite)     nextState = READ;
            else                       nextState = WRITE;
         end
         WRITE:   if (endTransactionIn) nextState = IDLE;
         READ: begin
            dataValidOut = 1'b1;
            if (remaining == '0) nextState = ENDREAD;
         end
         ENDREAD: begin
            endTransactionOut = 1'b1;
            nextState         = IDLE;
         end
         ERROR: begin
            busErrorOut = 1'b1;
            nextState   = WAITEND;
         end
         WAITEND: if (endTransactionIn) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign laneMask       = {{8{byteEnables[3]}}, {8{byteEnables[2]}}, {8{byteEnables[1]}}, {8{byteEnables[0]}}};
   assign addressDataOut = dataValidOut ? (ramReadA & laneMask) : '0;

   always_ff @(posedge systemClock) begin
      if (reset) begin
         ciDone    <= 1'b0;
         ciFromRam <= 1'b0;
         ciValue   <= '0;
      end else begin
         ciDone    <= ciActive;
         ciFromRam <= ciActive && ciKnown && (ciCommand == CI_READ_WORD);
         if (ciActive) begin
            ciValue <= '0;
            if (ciKnown && (ciCommand == CI_READ_COUNTER)) ciValue <= writeCounter;
            if (ciKnown && (ciCommand == CI_GET_DEPTH))    ciValue <= 32'(DEPTH);
         end
      end
   end

   assign ciResult = ciDone ? (ciFromRam ? ramReadB : ciValue) : '0;

endmodule

// File: tb/tb_feature_memory_slave.sv
// Directed self-checking bench for feature_memory_slave: bus bursts, error paths, CI port and reset.
module tb_feature_memory_slave;

   logic        systemClock = 1'b0;
   logic        reset = 1'b1;
   logic        beginTransactionIn = 1'b0;
   logic [31:0] addressDataIn = '0;
   logic        endTransactionIn = 1'b0;
   logic [3:0]  byteEnablesIn = '0;
   logic        readNotWriteIn = 1'b0;
   logic [7:0]  burstSizeIn = '0;
   logic        dataValidIn = 1'b0;
   logic        busyOut, busErrorOut, dataValidOut, endTransactionOut;
   logic [31:0] addressDataOut;
   logic        ciStart = 1'b0, ciCke = 1'b0;
   logic [7:0]  ciN = '0;
   logic [31:0] ciValueA = '0, ciValueB = '0;
   logic [31:0] ciResult;
   logic        ciDone;

   int checkCount = 0;
   int passCount  = 0;

   feature_memory_slave #(
      .BASE_ADDRESS(32'h5000_0000),
      .ADDRESS_WIDTH(6),
      .CUSTOM_INSTRUCTION_ID(8'd1)
   ) dut (
      .systemClock(systemClock), .reset(reset),
      .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
      .endTransactionIn(endTransactionIn), .byteEnablesIn(byteEnablesIn),
      .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn), .dataValidIn(dataValidIn),
      .busyOut(busyOut), .busErrorOut(busErrorOut), .addressDataOut(addressDataOut),
      .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
      .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
      .ciResult(ciResult), .ciDone(ciDone)
   );

   always #5 systemClock = ~systemClock;

   task automatic tick();
      @(posedge systemClock);
      #1;
   endtask

   // Leaves the bench in the cycle after begin (DECODE when the address hits).
   task automatic beginBurst(input logic [31:0] addr, input logic rnw, input logic [7:0] size, input logic [3:0] be);
      beginTransactionIn = 1'b1;
      addressDataIn      = addr;
      readNotWriteIn     = rnw;
      burstSizeIn        = size;
      byteEnablesIn      = be;
      tick();
      beginTransactionIn = 1'b0;
      addressDataIn      = '0;
   endtask

   task automatic writeBeat(input logic [31:0] data, input logic last);
      dataValidIn      = 1'b1;
      addressDataIn    = data;
      endTransactionIn = last;
      tick();
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
      addressDataIn    = '0;
   endtask

   task automatic ciIssue(input logic [31:0] cmd, input logic [31:0] operand);
      ciStart  = 1'b1;
      ciCke    = 1'b1;
      ciN      = 8'd1;
      ciValueA = cmd;
      ciValueB = operand;
      tick();
      ciStart  = 1'b0;
      ciCke    = 1'b0;
      ciN      = '0;
      ciValueA = '0;
      ciValueB = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checkCount++;
      if ({busyOut, busErrorOut, addressDataOut, dataValidOut, endTransactionOut, ciResult, ciDone} !== '0)
         $display("FAIL reset_outputs: got busy=%b err=%b data=%h dv=%b end=%b ci=%h done=%b expected all 0",
                  busyOut, busErrorOut, addressDataOut, dataValidOut, endTransactionOut, ciResult, ciDone);
      else passCount++;
      reset = 1'b0;
      tick();
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciDone !== 1'b1 || ciResult !== 32'd0)
         $display("FAIL reset_counter: got done=%b result=%h expected done=1 result=0", ciDone, ciResult);
      else passCount++;
   endtask

   task automatic test_write_burst();
      beginBurst(32'h5000_0000, 1'b0, 8'd3, 4'hF);
      checkCount++;
      if (busyOut !== 1'b1) $display("FAIL write_busy_decode: got %b expected 1", busyOut);
      else passCount++;
      tick();
      checkCount++;
      if (busyOut !== 1'b0) $display("FAIL write_busy_after: got %b expected 0", busyOut);
      else passCount++;
      writeBeat(32'd1, 1'b0);
      writeBeat(32'd2, 1'b0);
      writeBeat(32'd3, 1'b0);
      writeBeat(32'd4, 1'b1);
      ciIssue(32'd0, 32'd2);
      checkCount++;
      if (ciDone !== 1'b1 || ciResult !== 32'd3)
         $display("FAIL ci_read_word2: got done=%b result=%h expected done=1 result=3", ciDone, ciResult);
      else passCount++;
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd4) $display("FAIL ci_counter_4: got %h expected 4", ciResult);
      else passCount++;
      tick();
      checkCount++;
      if (ciDone !== 1'b0 || ciResult !== 32'd0)
         $display("FAIL ci_idle_zero: got done=%b result=%h expected 0/0", ciDone, ciResult);
      else passCount++;
   endtask

   task automatic test_read_burst();
      logic errSeen;
      beginBurst(32'h5000_0008, 1'b1, 8'd1, 4'hF);
      errSeen = busErrorOut;
      checkCount++;
      if (dataValidOut !== 1'b0 || addressDataOut !== 32'd0)
         $display("FAIL read_decode_quiet: got dv=%b data=%h expected 0/0", dataValidOut, addressDataOut);
      else passCount++;
      tick();
      errSeen |= busErrorOut;
      checkCount++;
      if (dataValidOut !== 1'b1 || addressDataOut !== 32'd3)
         $display("FAIL read_beat0: got dv=%b data=%h expected dv=1 data=3", dataValidOut, addressDataOut);
      else passCount++;
      tick();
      errSeen |= busErrorOut;
      checkCount++;
      if (dataValidOut !== 1'b1 || addressDataOut !== 32'd4)
         $display("FAIL read_beat1: got dv=%b data=%h expected dv=1 data=4", dataValidOut, addressDataOut);
      else passCount++;
      tick();
      errSeen |= busErrorOut;
      checkCount++;
      if (endTransactionOut !== 1'b1 || dataValidOut !== 1'b0)
         $display("FAIL read_end: got end=%b dv=%b expected end=1 dv=0", endTransactionOut, dataValidOut);
      else passCount++;
      tick();
      errSeen |= busErrorOut;
      checkCount++;
      if (endTransactionOut !== 1'b0 || errSeen !== 1'b0)
         $display("FAIL read_end_pulse: got end=%b errSeen=%b expected 0/0", endTransactionOut, errSeen);
      else passCount++;
   endtask

   task automatic test_overrun();
      beginBurst(32'h5000_00FC, 1'b0, 8'd0, 4'hF);
      tick();
      writeBeat(32'h1234_5678, 1'b1);
      beginBurst(32'h5000_00FC, 1'b0, 8'd1, 4'hF);
      checkCount++;
      if (busErrorOut !== 1'b0) $display("FAIL overrun_err_early: got %b expected 0", busErrorOut);
      else passCount++;
      tick();
      checkCount++;
      if (busErrorOut !== 1'b1) $display("FAIL overrun_err_pulse: got %b expected 1", busErrorOut);
      else passCount++;
      dataValidIn   = 1'b1;
      addressDataIn = 32'hDEAD_BEEF;
      tick();
      checkCount++;
      if (busErrorOut !== 1'b0) $display("FAIL overrun_err_once: got %b expected 0", busErrorOut);
      else passCount++;
      dataValidIn = 1'b0;
      writeBeat(32'hDEAD_BEEF, 1'b1);
      beginBurst(32'h5000_00FC, 1'b1, 8'd0, 4'hF);
      checkCount++;
      if (busyOut !== 1'b1) $display("FAIL overrun_back_idle: got busy=%b expected 1", busyOut);
      else passCount++;
      tick();
      checkCount++;
      if (dataValidOut !== 1'b1 || addressDataOut !== 32'h1234_5678)
         $display("FAIL overrun_mem_kept: got dv=%b data=%h expected dv=1 data=12345678", dataValidOut, addressDataOut);
      else passCount++;
      tick();
      tick();
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd5) $display("FAIL overrun_counter: got %h expected 5", ciResult);
      else passCount++;
   endtask

   task automatic test_miss();
      logic activity;
      beginBurst(32'h6000_0000, 1'b0, 8'd0, 4'hF);
      activity = busyOut | busErrorOut;
      tick();
      activity |= busyOut | busErrorOut;
      writeBeat(32'h1111_1111, 1'b1);
      activity |= busyOut | busErrorOut;
      checkCount++;
      if (activity !== 1'b0) $display("FAIL miss_quiet: got activity=%b expected 0", activity);
      else passCount++;
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd5) $display("FAIL miss_counter: got %h expected 5", ciResult);
      else passCount++;
   endtask

   task automatic test_write_overflow_beat();
      beginBurst(32'h5000_0028, 1'b0, 8'd0, 4'hF);
      tick();
      writeBeat(32'h0000_00AA, 1'b0);
      dataValidIn   = 1'b1;
      addressDataIn = 32'h0000_00BB;
      #1;
      checkCount++;
      if (busErrorOut !== 1'b1) $display("FAIL extra_beat_err: got %b expected 1", busErrorOut);
      else passCount++;
      tick();
      dataValidIn = 1'b0;
      writeBeat(32'h0000_00CC, 1'b1);
      ciIssue(32'd0, 32'd10);
      checkCount++;
      if (ciResult !== 32'h0000_00AA) $display("FAIL extra_beat_dropped: got %h expected 000000aa", ciResult);
      else passCount++;
   endtask

   task automatic test_byte_enables();
      beginBurst(32'h5000_0014, 1'b0, 8'd0, 4'hF);
      tick();
      writeBeat(32'hFFFF_FFFF, 1'b1);
      beginBurst(32'h5000_0014, 1'b0, 8'd0, 4'b0011);
      tick();
      writeBeat(32'hAABB_CCDD, 1'b1);
      ciIssue(32'd0, 32'd5);
      checkCount++;
      if (ciResult !== 32'hFFFF_CCDD) $display("FAIL be_partial_write: got %h expected ffffccdd", ciResult);
      else passCount++;
      beginBurst(32'h5000_0014, 1'b1, 8'd0, 4'b0011);
      tick();
      checkCount++;
      if (addressDataOut !== 32'h0000_CCDD) $display("FAIL be_masked_read: got %h expected 0000ccdd", addressDataOut);
      else passCount++;
      tick();
      tick();
   endtask

   task automatic test_ci_commands();
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd8) $display("FAIL ci_counter_8: got %h expected 8", ciResult);
      else passCount++;
      ciIssue(32'd3, 32'd0);
      checkCount++;
      if (ciResult !== 32'd64) $display("FAIL ci_depth: got %h expected 40", ciResult);
      else passCount++;
      ciIssue(32'd7, 32'd0);
      checkCount++;
      if (ciDone !== 1'b1 || ciResult !== 32'd0)
         $display("FAIL ci_unknown: got done=%b result=%h expected done=1 result=0", ciDone, ciResult);
      else passCount++;
      ciIssue(32'd2, 32'd0);
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd0) $display("FAIL ci_clear: got %h expected 0", ciResult);
      else passCount++;
      ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd2; ciValueA = 32'd3;
      tick();
      ciStart = 1'b0; ciCke = 1'b0; ciN = '0; ciValueA = '0;
      checkCount++;
      if (ciDone !== 1'b0) $display("FAIL ci_other_id: got done=%b expected 0", ciDone);
      else passCount++;
      beginBurst(32'h5000_0050, 1'b0, 8'd1, 4'hF);
      tick();
      writeBeat(32'd7, 1'b0);
      ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd1; ciValueA = 32'd2;
      writeBeat(32'd8, 1'b1);
      ciStart = 1'b0; ciCke = 1'b0; ciN = '0; ciValueA = '0;
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd0) $display("FAIL ci_clear_wins: got %h expected 0", ciResult);
      else passCount++;
      ciIssue(32'd0, 32'd21);
      checkCount++;
      if (ciResult !== 32'd8) $display("FAIL ci_clear_write_kept: got %h expected 8", ciResult);
      else passCount++;
   endtask

   task automatic test_reset_mid_burst();
      beginBurst(32'h5000_0000, 1'b0, 8'd15, 4'hF);
      tick();
      writeBeat(32'h100, 1'b0);
      writeBeat(32'h101, 1'b0);
      dataValidIn   = 1'b1;
      addressDataIn = 32'h102;
      reset         = 1'b1;
      tick();
      dataValidIn   = 1'b0;
      addressDataIn = '0;
      checkCount++;
      if ({busyOut, busErrorOut, addressDataOut, dataValidOut, endTransactionOut, ciResult, ciDone} !== '0)
         $display("FAIL midreset_outputs: got busy=%b err=%b data=%h dv=%b end=%b ci=%h done=%b expected all 0",
                  busyOut, busErrorOut, addressDataOut, dataValidOut, endTransactionOut, ciResult, ciDone);
      else passCount++;
      reset = 1'b0;
      tick();
      ciIssue(32'd1, 32'd0);
      checkCount++;
      if (ciResult !== 32'd0) $display("FAIL midreset_counter: got %h expected 0", ciResult);
      else passCount++;
      ciIssue(32'd0, 32'd0);
      checkCount++;
      if (ciResult !== 32'h100) $display("FAIL midreset_word0: got %h expected 00000100", ciResult);
      else passCount++;
      ciIssue(32'd0, 32'd1);
      checkCount++;
      if (ciResult !== 32'h101) $display("FAIL midreset_word1: got %h expected 00000101", ciResult);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_overrun();
      test_miss();
      test_write_overflow_beat();
      test_byte_enables();
      test_ci_commands();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
